// File: rtl/pipe_field_renderer_if.sv
// Bus for the pipe field renderer: game-control inputs, raster position, pixel and score outputs.
interface pipe_field_renderer_if;
    logic        MoveTick;
    logic        Button;
    logic        Status;
    logic [15:0] GapTop;
    logic [15:0] CounterX;
    logic [15:0] CounterY;
    logic        PixGreen;
    logic        PixBlack;
    logic [15:0] NearestX;
    logic [15:0] NearestGap;
    logic        ScorePulse;

    modport master (
        output MoveTick, Button, Status, GapTop, CounterX, CounterY,
        input  PixGreen, PixBlack, NearestX, NearestGap, ScorePulse
    );

    modport slave (
        input  MoveTick, Button, Status, GapTop, CounterX, CounterY,
        output PixGreen, PixBlack, NearestX, NearestGap, ScorePulse
    );
endinterface

// File: rtl/pipe_field_renderer.sv
// Scrolls NUM_PIPES pipe pairs, scores them against the bird column and rasterises them through a
// two-stage pixel path. Optional feature macro: PIPE_FIELD_SPEEDUP_EN (score-driven scroll speedup).
module pipe_field_renderer #(
    parameter int NUM_PIPES = 3,
    parameter int PIPE_W    = 90,
    parameter int GAP_H     = 150,
    parameter int SPACING   = 240,
    parameter int SCREEN_W  = 640,
    parameter int GROUND_Y  = 428,
    parameter int BIRD_X    = 160
) (
    input logic                  Clks,
    input logic                  Reset,
    pipe_field_renderer_if.slave bus
);
    localparam logic [15:0] PIPE_W16   = 16'(PIPE_W);
    localparam logic [15:0] GAP_H16    = 16'(GAP_H);
    localparam logic [15:0] SCREEN_W16 = 16'(SCREEN_W);
    localparam logic [15:0] GROUND_Y16 = 16'(GROUND_Y);
    localparam logic [15:0] BIRD_X16   = 16'(BIRD_X);
    localparam logic [15:0] INSET      = 16'(PIPE_W / 10);
    localparam logic [15:0] OUTLINE    = 16'(PIPE_W / 30);
    localparam logic [15:0] CAP_H      = 16'd33;
    localparam logic [15:0] Y_INIT     = 16'd100;
    localparam logic [15:0] GAP_MIN    = 16'd40;
    localparam logic [15:0] GAP_MAX    = 16'(GROUND_Y - GAP_H - 40);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } stateT;

    stateT                        state;
    stateT                        stateNext;
    logic                         tickPending;
    logic                         inWindow;
    logic                         doMove;
    logic [15:0]                  stepVal;
    logic [NUM_PIPES-1:0][15:0]   pipeXs;
    logic [NUM_PIPES-1:0][15:0]   pipeYs;
    logic [NUM_PIPES-1:0]         scoredVec;
    logic [NUM_PIPES-1:0]         newScore;
    logic [NUM_PIPES-1:0]         blackStage;
    logic [NUM_PIPES-1:0]         greenStage;
    logic [3:0]                   newCount;
    logic [3:0]                   scoreQueue;
    logic [3:0]                   queueNext;
    logic [15:0]                  bestX;
    logic [15:0]                  bestGap;
    logic                         bestValid;
    logic [15:0]                  nearestX;
    logic [15:0]                  nearestGap;
    logic                         scorePulse;
    logic                         pixGreen;
    logic                         pixBlack;

    function automatic logic [15:0] clampGap(input logic [15:0] raw);
        logic [15:0] res;
        if (raw < GAP_MIN) begin
            res = GAP_MIN;
        end else if (raw > GAP_MAX) begin
            res = GAP_MAX;
        end else begin
            res = raw;
        end
        return res;
    endfunction

    // Game state register
    always_ff @(posedge Clks) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Game state transitions; FROZEN is left only through Reset
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (!bus.Button) stateNext = RUN;
                else             stateNext = IDLE;
            end
            RUN: begin
                if (!bus.Status) stateNext = FROZEN;
                else             stateNext = RUN;
            end
            FROZEN:  stateNext = FROZEN;
            default: stateNext = IDLE;
        endcase
    end

    // Positions only change during vblank so a frame never shows two pipe positions
    assign inWindow = bus.CounterY > GROUND_Y16;
    assign doMove   = (state == RUN) && inWindow && (bus.MoveTick || tickPending);

    // Remembers a scroll tick that arrived while the raster was still drawing
    always_ff @(posedge Clks) begin
        if (!Reset) begin
            tickPending <= 1'b0;
        end else if (doMove) begin
            tickPending <= 1'b0;
        end else if ((state == RUN) && bus.MoveTick) begin
            tickPending <= 1'b1;
        end else begin
            tickPending <= tickPending;
        end
    end

`ifdef PIPE_FIELD_SPEEDUP_EN
    logic [2:0] scoreCount;
    logic [2:0] stepR;

    // Every eighth score pulse raises the scroll step, saturating at 4
    always_ff @(posedge Clks) begin
        if (!Reset) begin
            scoreCount <= 3'd0;
            stepR      <= 3'd1;
        end else if (scorePulse) begin
            scoreCount <= scoreCount + 3'd1;
            if ((scoreCount == 3'd7) && (stepR < 3'd4)) begin
                stepR <= stepR + 3'd1;
            end else begin
                stepR <= stepR;
            end
        end else begin
            scoreCount <= scoreCount;
            stepR      <= stepR;
        end
    end

    assign stepVal = {13'd0, stepR};
`else
    assign stepVal = 16'd1;
`endif

    for (genvar g = 0; g < NUM_PIPES; g++) begin : gPipe
        localparam logic [15:0] X_INIT = 16'(SCREEN_W + 320 + g * SPACING);

        logic [15:0] posX;
        logic [15:0] posY;
        logic [15:0] posXNext;
        logic [15:0] posYNext;
        logic        scoredFlag;
        logic        scoredNext;
        logic        hitScore;
        logic        wrapNow;
        logic [15:0] relX;
        logic [15:0] relYCap;
        logic [15:0] botCapY;
        logic [15:0] botBodyY;
        logic        inColumn;
        logic        inTopCap;
        logic        inBotCap;
        logic        inBody;
        logic        inBodyCol;
        logic        capEdge;
        logic        bodyEdge;
        logic        capHit;
        logic        bodyHit;
        logic        blackS;
        logic        greenS;
        logic        blackR;
        logic        greenR;

        // Scroll, wrap-reload and score-flag next state for this pipe
        always_comb begin
            posXNext   = posX;
            posYNext   = posY;
            wrapNow    = 1'b0;
            hitScore   = 1'b0;
            scoredNext = scoredFlag;
            if (doMove) begin
                if (posX < stepVal) begin
                    posXNext = SCREEN_W16;
                    posYNext = clampGap(bus.GapTop);
                    wrapNow  = 1'b1;
                end else begin
                    posXNext = posX - stepVal;
                end
            end else begin
                posXNext = posX;
            end
            hitScore = (state == RUN) && !scoredFlag && ((posX + PIPE_W16) < BIRD_X16);
            if (wrapNow) begin
                scoredNext = 1'b0;
            end else begin
                scoredNext = scoredFlag | hitScore;
            end
        end

        // Stage-1 region compares; columns past the screen edge are clipped, never wrapped
        always_comb begin
            relX      = bus.CounterX - posX;
            botCapY   = posY + GAP_H16;
            botBodyY  = botCapY + CAP_H;
            inColumn  = (bus.CounterX >= posX) && (relX < PIPE_W16) && (bus.CounterX < SCREEN_W16);
            inTopCap  = (bus.CounterY >= posY) && (bus.CounterY < (posY + CAP_H));
            inBotCap  = (bus.CounterY >= botCapY) && (bus.CounterY < botBodyY);
            inBody    = (bus.CounterY < posY) ||
                        ((bus.CounterY >= botBodyY) && (bus.CounterY <= GROUND_Y16));
            if (inTopCap) begin
                relYCap = bus.CounterY - posY;
            end else begin
                relYCap = bus.CounterY - botCapY;
            end
            inBodyCol = (relX >= INSET) && (relX < (PIPE_W16 - INSET));
            capEdge   = (relX < OUTLINE) || (relX >= (PIPE_W16 - OUTLINE)) ||
                        (relYCap < OUTLINE) || (relYCap >= (CAP_H - OUTLINE));
            bodyEdge  = (relX < (INSET + OUTLINE)) || (relX >= (PIPE_W16 - INSET - OUTLINE));
            capHit    = inColumn && (inTopCap || inBotCap);
            bodyHit   = inColumn && inBody && inBodyCol;
            blackS    = (capHit && capEdge) || (bodyHit && bodyEdge);
            greenS    = (capHit && !capEdge) || (bodyHit && !bodyEdge);
        end

        // Per-pipe position, score flag and stage-1 pixel registers
        always_ff @(posedge Clks) begin
            if (!Reset) begin
                posX       <= X_INIT;
                posY       <= Y_INIT;
                scoredFlag <= 1'b0;
                blackR     <= 1'b0;
                greenR     <= 1'b0;
            end else begin
                posX       <= posXNext;
                posY       <= posYNext;
                scoredFlag <= scoredNext;
                blackR     <= blackS;
                greenR     <= greenS;
            end
        end

        assign pipeXs[g]     = posX;
        assign pipeYs[g]     = posY;
        assign scoredVec[g]  = scoredFlag;
        assign newScore[g]   = hitScore;
        assign blackStage[g] = blackR;
        assign greenStage[g] = greenR;
    end

    // Score backlog so simultaneous scores leave as pulses on consecutive cycles
    always_comb begin
        newCount = 4'd0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            newCount = newCount + {3'd0, newScore[i]};
        end
        queueNext = scoreQueue - {3'd0, (scoreQueue != 4'd0)} + newCount;
    end

    // Leftmost unscored pipe is the next obstacle ahead of the bird
    always_comb begin
        bestX     = 16'd0;
        bestGap   = 16'd0;
        bestValid = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (!scoredVec[i] && (!bestValid || (pipeXs[i] < bestX))) begin
                bestX     = pipeXs[i];
                bestGap   = pipeYs[i];
                bestValid = 1'b1;
            end else begin
                bestValid = bestValid;
            end
        end
    end

    // Output registers: score pulse, nearest pipe, and stage-2 pixel merge (outline wins)
    always_ff @(posedge Clks) begin
        if (!Reset) begin
            scoreQueue <= 4'd0;
            scorePulse <= 1'b0;
            nearestX   <= 16'd0;
            nearestGap <= 16'd0;
            pixBlack   <= 1'b0;
            pixGreen   <= 1'b0;
        end else begin
            scoreQueue <= queueNext;
            scorePulse <= (scoreQueue != 4'd0);
            nearestX   <= bestX;
            nearestGap <= bestGap;
            pixBlack   <= |blackStage;
            pixGreen   <= (|greenStage) & ~(|blackStage);
        end
    end

    assign bus.PixGreen   = pixGreen;
    assign bus.PixBlack   = pixBlack;
    assign bus.NearestX   = nearestX;
    assign bus.NearestGap = nearestGap;
    assign bus.ScorePulse = scorePulse;
endmodule

// File: tb/tb_pipe_field_renderer.sv
// Directed bench for pipe_field_renderer: scroll, pending ticks, wrap/clamp, scoring, pixels, reset.
module tb_pipe_field_renderer;
    logic Clks = 1'b0;
    logic Reset;
    int   checks     = 0;
    int   errors     = 0;
    int   pulseCount = 0;

    pipe_field_renderer_if bus();

    pipe_field_renderer dut (
        .Clks  (Clks),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clks = ~Clks;

    task automatic step();
        @(posedge Clks);
        #1;
        if (bus.ScorePulse === 1'b1) pulseCount++;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic moveN(input int n);
        bus.MoveTick = 1'b1;
        repeat (n) step();
        bus.MoveTick = 1'b0;
        repeat (3) step();
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic g, input logic b);
        bus.CounterX = 16'(x);
        bus.CounterY = 16'(y);
        step();
        step();
        check({tag, " green"}, {15'd0, bus.PixGreen}, {15'd0, g});
        check({tag, " black"}, {15'd0, bus.PixBlack}, {15'd0, b});
    endtask

    initial begin
        Reset        = 1'b0;
        bus.MoveTick = 1'b0;
        bus.Button   = 1'b1;
        bus.Status   = 1'b1;
        bus.GapTop   = 16'd0;
        bus.CounterX = 16'd45;
        bus.CounterY = 16'd50;
        repeat (3) step();
        check("reset NearestX", bus.NearestX, 16'd0);
        check("reset NearestGap", bus.NearestGap, 16'd0);
        check("reset PixGreen", {15'd0, bus.PixGreen}, 16'd0);
        check("reset PixBlack", {15'd0, bus.PixBlack}, 16'd0);
        check("reset ScorePulse", {15'd0, bus.ScorePulse}, 16'd0);

        Reset = 1'b1;
        step();
        step();
        check("init NearestX", bus.NearestX, 16'd960);
        check("init NearestGap", bus.NearestGap, 16'd100);

        // IDLE ignores scroll ticks
        bus.CounterY = 16'd500;
        moveN(5);
        check("idle no move", bus.NearestX, 16'd960);

        bus.Button = 1'b0;
        step();
        bus.Button = 1'b1;
        moveN(10);
        check("run 10 ticks", bus.NearestX, 16'd950);

        // Tick outside vblank waits for the window, and moves exactly once
        bus.CounterY = 16'd100;
        bus.MoveTick = 1'b1;
        step();
        bus.MoveTick = 1'b0;
        repeat (3) step();
        check("pending held", bus.NearestX, 16'd950);
        bus.CounterY = 16'd500;
        repeat (3) step();
        check("pending applied once", bus.NearestX, 16'd949);

        moveN(879);
        check("pipe0 at 70", bus.NearestX, 16'd70);
        check("no score at 160", pulseCount[15:0], 16'd0);
        moveN(1);
        check("one score at 159", pulseCount[15:0], 16'd1);
        check("nearest after score", bus.NearestX, 16'd309);

        moveN(69);
        check("pipe1 at 240", bus.NearestX, 16'd240);
        check("pulses unchanged", pulseCount[15:0], 16'd1);

        // Pipe 0 at X=0, Y=100
        pix("body fill", 45, 50, 1'b1, 1'b0);
        pix("body strip", 10, 50, 1'b0, 1'b1);
        pix("body inset", 8, 50, 1'b0, 1'b0);
        pix("top cap fill", 45, 120, 1'b1, 1'b0);
        pix("top cap ring", 45, 101, 1'b0, 1'b1);
        pix("gap", 45, 200, 1'b0, 1'b0);
        pix("bottom cap ring", 45, 282, 1'b0, 1'b1);
        pix("ground row", 45, 428, 1'b1, 1'b0);
        pix("below ground", 45, 429, 1'b0, 1'b0);

        bus.CounterX = 16'd0;
        bus.CounterY = 16'd500;
        bus.GapTop   = 16'd300;
        moveN(1);
        check("after wrap nearest", bus.NearestX, 16'd239);

        moveN(100);
        check("nearest pipe1", bus.NearestX, 16'd139);
        // Wrapped pipe 0 now at X=540 with Y clamped to 238
        pix("wrap inset", 548, 200, 1'b0, 1'b0);
        pix("wrap strip", 549, 200, 1'b0, 1'b1);
        pix("wrap body", 585, 200, 1'b1, 1'b0);
        pix("wrap cap ring", 585, 240, 1'b0, 1'b1);
        pix("wrap cap fill", 585, 253, 1'b1, 1'b0);

        bus.CounterX = 16'd0;
        bus.CounterY = 16'd500;
        bus.GapTop   = 16'd10;
        moveN(310);
        check("two more scores", pulseCount[15:0], 16'd3);
        check("pipe0 unscored", bus.NearestX, 16'd230);
        check("pipe0 gap clamp high", bus.NearestGap, 16'd238);
        // Pipe 1 wrapped to X=470 with Y clamped to 40
        pix("low clamp cap", 515, 45, 1'b1, 1'b0);

        bus.CounterY = 16'd500;
        bus.Status   = 1'b0;
        step();
        bus.Status   = 1'b1;
        bus.Button   = 1'b0;
        moveN(20);
        bus.Button   = 1'b1;
        check("frozen X", bus.NearestX, 16'd230);
        check("frozen pulses", pulseCount[15:0], 16'd3);

        // Back to RUN, then reset with tick and button active
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        step();
        bus.Button = 1'b0;
        step();
        bus.Button = 1'b1;
        moveN(5);
        check("rerun 5 ticks", bus.NearestX, 16'd955);
        bus.MoveTick = 1'b1;
        bus.Button   = 1'b0;
        bus.CounterX = 16'd45;
        Reset        = 1'b0;
        step();
        check("midrun reset NearestX", bus.NearestX, 16'd0);
        check("midrun reset NearestGap", bus.NearestGap, 16'd0);
        check("midrun reset PixGreen", {15'd0, bus.PixGreen}, 16'd0);
        check("midrun reset ScorePulse", {15'd0, bus.ScorePulse}, 16'd0);
        bus.MoveTick = 1'b0;
        bus.Button   = 1'b1;
        Reset        = 1'b1;
        step();
        step();
        check("post reset NearestX", bus.NearestX, 16'd960);
        check("post reset NearestGap", bus.NearestGap, 16'd100);
        moveN(5);
        check("post reset idle", bus.NearestX, 16'd960);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
